// File: rtl/fir_pkg.sv
// Shared definitions for the FIR input feeder: feeder state encoding,
// the default sample width and a constant-foldable ceil(log2) helper.
package fir_pkg;

   typedef enum logic {
      FEED_IDLE = 1'b0,
      FEED_WAIT = 1'b1
   } feed_state_t;

   localparam int FIR_IN_WIDTH = 16;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter. The head entry is visible on
// rd_data combinationally; a pop simply advances the read pointer. A write
// is refused while full even if a read happens on the same edge.
module sync_fifo
   import fir_pkg::*;
#(
   parameter int WIDTH = FIR_IN_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic [clog2(DEPTH):0] level,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage write; contents need no reset because level gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/fir_input_feeder.sv
// Feeds a multi-cycle serial-MAC FIR one sample at a time. Samples are
// buffered in a FIFO; each is issued as a one-cycle fir_valid pulse, then the
// feeder waits for a rising edge on fir_done (or a timeout) before issuing
// the next one.
//
// Upstream handshake: a sample transfers on any edge where s_valid && s_ready.
// s_ready depends only on FIFO occupancy (never on s_valid), and s_valid
// while !s_ready is not back-pressured: the sample is dropped and the sticky
// overflow flag is raised.
module fir_input_feeder
   import fir_pkg::*;
#(
   parameter int IN_WIDTH = FIR_IN_WIDTH,
   parameter int DEPTH    = 8,
   parameter int TIMEOUT  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_WIDTH-1:0]   s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [IN_WIDTH-1:0]   fir_data,
   output logic                  fir_valid,
   input  logic                  fir_done,
   output logic [clog2(DEPTH):0] level,
   output logic                  busy,
   output logic                  overflow,
   output logic                  timeout_err,
   input  logic                  clr_flags,
   output feed_state_t           state_dbg
);

   localparam int CW = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   feed_state_t         state;
   feed_state_t         state_nxt;
   logic [IN_WIDTH-1:0] head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                done_q;
   logic                done_rise;
   logic                issue;
   logic                to_fire;
   logic                cnt_inc;
   logic [CW-1:0]       cnt;

   sync_fifo #(
      .WIDTH (IN_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (s_valid),
      .wr_data (s_data),
      .rd_en   (issue),
      .rd_data (head),
      .level   (level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign s_ready   = !fifo_full;
   assign done_rise = fir_done && !done_q;
   assign busy      = (state == FEED_WAIT);
   assign state_dbg = state;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FEED_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: issue from IDLE when data is queued; leave WAIT on a
   // fir_done rise or when the wait budget is exhausted.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      to_fire   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         FEED_IDLE: begin
            if (!fifo_empty) begin
               issue     = 1'b1;
               state_nxt = FEED_WAIT;
            end
         end
         FEED_WAIT: begin
            if (done_rise) begin
               state_nxt = FEED_IDLE;
            end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
               to_fire   = 1'b1;
               state_nxt = FEED_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_nxt = FEED_IDLE;
      endcase
   end

   // Completion edge detect; a FIR holding output_valid high yields one rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= fir_done;
      end
   end

   // Issue datapath: fir_data only changes on an issue, fir_valid is a pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         fir_data  <= '0;
         fir_valid <= 1'b0;
      end else begin
         fir_valid <= issue;
         if (issue) begin
            fir_data <= head;
         end
      end
   end

   // Wait-cycle counter, restarted on every issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (issue) begin
         cnt <= '0;
      end else if (cnt_inc) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // Sticky error flags; a set event on the same edge as clr_flags wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (s_valid && fifo_full) begin
            overflow <= 1'b1;
         end else if (clr_flags) begin
            overflow <= 1'b0;
         end
         if (to_fire) begin
            timeout_err <= 1'b1;
         end else if (clr_flags) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_input_feeder.sv
// Bench for fir_input_feeder. Two instances share all inputs: dut_a with the
// default TIMEOUT=256 and dut_b with TIMEOUT=16. A queue-based model of each
// instance advances on every rising edge; all outputs are compared against it
// on every falling edge, and directed phases add hand-computed literal checks.
module tb_fir_input_feeder;
   import fir_pkg::*;

   localparam int W     = 16;
   localparam int DEPTH = 8;
   localparam int TO_A  = 256;
   localparam int TO_B  = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic [W-1:0] s_data = '0;
   logic         s_valid = 1'b0;
   logic         clr_flags = 1'b0;
   logic         done_man = 1'b0;
   logic         done_auto = 1'b0;
   wire          fir_done;
   assign fir_done = done_man | done_auto;

   logic         a_s_ready, b_s_ready;
   logic [W-1:0] a_data, b_data;
   logic         a_valid, b_valid;
   logic [3:0]   a_level, b_level;
   logic         a_busy, b_busy;
   logic         a_ovf, b_ovf;
   logic         a_terr, b_terr;
   feed_state_t  a_state, b_state;

   fir_input_feeder #(.IN_WIDTH(W), .DEPTH(DEPTH), .TIMEOUT(TO_A)) dut_a (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(a_s_ready),
      .fir_data(a_data), .fir_valid(a_valid), .fir_done(fir_done), .level(a_level),
      .busy(a_busy), .overflow(a_ovf), .timeout_err(a_terr), .clr_flags(clr_flags),
      .state_dbg(a_state)
   );

   fir_input_feeder #(.IN_WIDTH(W), .DEPTH(DEPTH), .TIMEOUT(TO_B)) dut_b (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(b_s_ready),
      .fir_data(b_data), .fir_valid(b_valid), .fir_done(fir_done), .level(b_level),
      .busy(b_busy), .overflow(b_ovf), .timeout_err(b_terr), .clr_flags(clr_flags),
      .state_dbg(b_state)
   );

   // ---------------- behavioural model ----------------
   logic [W-1:0] mq0[$];
   logic [W-1:0] mq1[$];
   bit           m_valid [2];
   logic [W-1:0] m_data  [2];
   bit           m_wait  [2];
   int           m_wcnt  [2];
   bit           m_ovf   [2];
   bit           m_terr  [2];
   bit           m_prev_done = 1'b0;

   task automatic model_step(input int idx, input bit rise);
      int n;
      int to;
      bit issue;
      bit to_ev;
      n  = (idx == 0) ? mq0.size() : mq1.size();
      to = (idx == 0) ? TO_A : TO_B;
      if (rst) begin
         if (idx == 0) mq0.delete(); else mq1.delete();
         m_valid[idx] = 1'b0;
         m_data[idx]  = '0;
         m_wait[idx]  = 1'b0;
         m_wcnt[idx]  = 0;
         m_ovf[idx]   = 1'b0;
         m_terr[idx]  = 1'b0;
         return;
      end
      issue = !m_wait[idx] && (n > 0);
      to_ev = 1'b0;
      m_valid[idx] = issue;
      if (issue) begin
         if (idx == 0) m_data[idx] = mq0.pop_front(); else m_data[idx] = mq1.pop_front();
         m_wait[idx] = 1'b1;
         m_wcnt[idx] = 0;
      end else if (m_wait[idx]) begin
         if (rise) begin
            m_wait[idx] = 1'b0;
         end else begin
            m_wcnt[idx] = m_wcnt[idx] + 1;
            if (to != 0 && m_wcnt[idx] == to) begin
               to_ev = 1'b1;
               m_wait[idx] = 1'b0;
            end
         end
      end
      // Acceptance uses the occupancy before this edge (no bypass when full).
      if (s_valid && n < DEPTH) begin
         if (idx == 0) mq0.push_back(s_data); else mq1.push_back(s_data);
      end
      if (s_valid && n == DEPTH) m_ovf[idx] = 1'b1;
      else if (clr_flags)        m_ovf[idx] = 1'b0;
      if (to_ev)          m_terr[idx] = 1'b1;
      else if (clr_flags) m_terr[idx] = 1'b0;
   endtask

   initial begin
      bit rise;
      forever begin
         @(posedge clk);
         rise = fir_done && !m_prev_done;
         m_prev_done = rst ? 1'b0 : fir_done;
         model_step(0, rise);
         model_step(1, rise);
      end
   end

   // ---------------- scoreboard / checking ----------------
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] a_log[$];
   int           a_issues = 0;
   bit           auto_on = 1'b0;
   int           resp_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("a_ready", 32'(a_s_ready), 32'(mq0.size() != DEPTH));
      chk("a_valid", 32'(a_valid),   32'(m_valid[0]));
      chk("a_data",  32'(a_data),    32'(m_data[0]));
      chk("a_level", 32'(a_level),   32'(mq0.size()));
      chk("a_busy",  32'(a_busy),    32'(m_wait[0]));
      chk("a_ovf",   32'(a_ovf),     32'(m_ovf[0]));
      chk("a_terr",  32'(a_terr),    32'(m_terr[0]));
      chk("a_state", 32'(a_state),   32'(m_wait[0] ? FEED_WAIT : FEED_IDLE));
      chk("b_ready", 32'(b_s_ready), 32'(mq1.size() != DEPTH));
      chk("b_valid", 32'(b_valid),   32'(m_valid[1]));
      chk("b_data",  32'(b_data),    32'(m_data[1]));
      chk("b_level", 32'(b_level),   32'(mq1.size()));
      chk("b_busy",  32'(b_busy),    32'(m_wait[1]));
      chk("b_ovf",   32'(b_ovf),     32'(m_ovf[1]));
      chk("b_terr",  32'(b_terr),    32'(m_terr[1]));
      chk("b_state", 32'(b_state),   32'(m_wait[1] ? FEED_WAIT : FEED_IDLE));
   endtask

   // Advance one cycle: compare at the falling edge, log issues, run the
   // scoreboard and the automatic fir_done responder.
   task automatic step();
      @(negedge clk);
      compare_all();
      if (a_valid) begin
         a_log.push_back(a_data);
         a_issues = a_issues + 1;
         if (auto_on) begin
            if (exp_q.size() == 0) chk("sb_unexpected", 32'(a_data), 32'hFFFF_FFFF);
            else                   chk("sb_data", 32'(a_data), 32'(exp_q.pop_front()));
         end
      end
      if (auto_on) begin
         done_auto = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) done_auto = 1'b1;
         end
         if (a_valid) resp_cnt = 3;
      end else begin
         done_auto = 1'b0;
         resp_cnt  = 0;
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic done_pulse();
      done_man = 1'b1;
      step();
      done_man = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int c0;
      int guard;
      logic [W-1:0] v;

      // Reset
      steps(2);
      rst = 1'b0;
      chk("rst_level", 32'(a_level), 32'd0);
      chk("rst_valid", 32'(a_valid), 32'd0);
      chk("rst_busy",  32'(a_busy),  32'd0);
      chk("rst_data",  32'(a_data),  32'd0);
      chk("rst_flags", 32'({a_ovf, a_terr}), 32'd0);

      // Single sample: latency of two edges, one-cycle pulse
      s_valid = 1'b1; s_data = 16'h1234;
      step();
      s_valid = 1'b0;
      chk("t1_level", 32'(a_level), 32'd1);
      chk("t1_no_valid_yet", 32'(a_valid), 32'd0);
      step();
      chk("t1_valid", 32'(a_valid), 32'd1);
      chk("t1_data",  32'(a_data),  32'h1234);
      chk("t1_busy",  32'(a_busy),  32'd1);
      step();
      chk("t1_pulse_end", 32'(a_valid), 32'd0);
      steps(14);
      chk("t1_b_terr_before", 32'(b_terr), 32'd0);
      chk("t1_b_busy_before", 32'(b_busy), 32'd1);
      step();
      chk("t1_b_terr_at16", 32'(b_terr), 32'd1);
      chk("t1_b_busy_at16", 32'(b_busy), 32'd0);

      // Burst of 8 while dut_a waits: fills to 8, ninth dropped
      for (int i = 1; i <= 8; i++) begin
         s_valid = 1'b1; s_data = W'(i);
         step();
      end
      chk("t2_level_full", 32'(a_level), 32'd8);
      chk("t2_not_ready",  32'(a_s_ready), 32'd0);
      chk("t2_ovf_clear",  32'(a_ovf), 32'd0);
      s_data = 16'h0009;
      step();
      s_valid = 1'b0;
      chk("t2_ovf_set",   32'(a_ovf), 32'd1);
      chk("t2_level_8",   32'(a_level), 32'd8);
      steps(14);
      chk("t2_still_busy", 32'(a_busy), 32'd1);
      chk("t2_data_held",  32'(a_data), 32'h1234);
      done_pulse();
      chk("t2_idle_after_rise", 32'(a_busy), 32'd0);
      step();
      chk("t2_issue1_valid", 32'(a_valid), 32'd1);
      chk("t2_issue1_data",  32'(a_data),  32'h0001);
      chk("t2_issue1_level", 32'(a_level), 32'd7);
      for (int k = 2; k <= 8; k++) begin
         steps(3);
         done_pulse();
         step();
         chk("t2_issue_valid", 32'(a_valid), 32'd1);
         chk("t2_issue_data",  32'(a_data),  32'(k));
      end
      steps(3);
      done_pulse();
      steps(6);
      chk("t2_issue_count", 32'(a_log.size()), 32'd9);
      chk("t2_drained",     32'(a_level), 32'd0);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      chk("t2_ovf_cleared", 32'(a_ovf), 32'd0);

      // Held fir_done releases exactly one issue
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_data = W'(16'h00A1 + i);
         step();
      end
      s_valid = 1'b0;
      chk("t3_level", 32'(a_level), 32'd2);
      c0 = a_issues;
      done_man = 1'b1;
      steps(20);
      chk("t3_one_issue",  32'(a_issues - c0), 32'd1);
      chk("t3_issue_data", 32'(a_log[$]), 32'h00A2);
      chk("t3_level_left", 32'(a_level), 32'd1);
      chk("t3_busy_held",  32'(a_busy), 32'd1);
      done_man = 1'b0;
      step();
      done_man = 1'b1;
      step();
      chk("t3_idle_on_new_rise", 32'(a_busy), 32'd0);
      step();
      chk("t3_third_valid", 32'(a_valid), 32'd1);
      chk("t3_third_data",  32'(a_data),  32'h00A3);
      done_man = 1'b0;
      steps(2);
      done_pulse();
      steps(60);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;

      // Timeout on dut_b (TIMEOUT=16), set-beats-clear
      s_valid = 1'b1; s_data = 16'h00B1;
      step();
      s_data = 16'h00B2;
      step();
      s_valid = 1'b0;
      chk("t4_b1_valid", 32'(b_valid), 32'd1);
      chk("t4_b1_data",  32'(b_data),  32'h00B1);
      steps(15);
      chk("t4_terr_before", 32'(b_terr), 32'd0);
      step();
      chk("t4_terr_set",   32'(b_terr), 32'd1);
      chk("t4_busy_clear", 32'(b_busy), 32'd0);
      step();
      chk("t4_b2_valid", 32'(b_valid), 32'd1);
      chk("t4_b2_data",  32'(b_data),  32'h00B2);
      steps(15);
      clr_flags = 1'b1;
      step();
      chk("t4_set_wins", 32'(b_terr), 32'd1);
      step();
      clr_flags = 1'b0;
      chk("t4_cleared", 32'(b_terr), 32'd0);
      done_pulse();
      steps(3);
      done_pulse();
      steps(3);

      // Reset in the middle of a wait with 4 samples queued
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1; s_data = W'(16'h00C1 + i);
         step();
      end
      s_valid = 1'b0;
      chk("t5_level_pre", 32'(a_level), 32'd4);
      chk("t5_busy_pre",  32'(a_busy),  32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_level", 32'(a_level), 32'd0);
      chk("t5_busy",  32'(a_busy),  32'd0);
      chk("t5_valid", 32'(a_valid), 32'd0);
      step();
      chk("t5_valid_after", 32'(a_valid), 32'd0);
      c0 = a_issues;
      done_pulse();
      steps(4);
      chk("t5_no_issue", 32'(a_issues - c0), 32'd0);

      // Wrap with automatic completions 3 cycles after each issue
      auto_on = 1'b1;
      for (int i = 0; i < 20; i++) begin
         guard = 0;
         while (!a_s_ready && guard < 50) begin
            step();
            guard = guard + 1;
         end
         chk("t6_ready_wait", 32'(a_s_ready), 32'd1);
         v = W'(16'h5000 + i * 16'h0123);
         s_valid = 1'b1; s_data = v;
         exp_q.push_back(v);
         step();
         s_valid = 1'b0;
         steps(i % 3);
      end
      guard = 0;
      while (exp_q.size() > 0 && guard < 400) begin
         step();
         guard = guard + 1;
      end
      chk("t6_drained", 32'(exp_q.size()), 32'd0);
      auto_on = 1'b0;
      steps(6);
      chk("t6_level", 32'(a_level), 32'd0);
      chk("t6_ovf",   32'(a_ovf),   32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
